// File: rtl/pe_sync_fifo.sv
// rtl/pe_sync_fifo.sv - gated single-clock FIFO between PE array stages
// Optional almost_full output enabled by defining SYNC_FIFO_ALMOST_FULL_EN.
module pe_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_gate,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear
`ifdef SYNC_FIFO_ALMOST_FULL_EN
    ,output logic                 almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == LP_DEPTH);
        w_do_pop  = rd_en & rd_gate & ~w_empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
        w_do_push = wr_en & (~w_full | w_do_pop);
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            // Flush keeps rd_data and the sticky error flags
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_do_pop;
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full && !w_do_pop) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && rd_gate && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

`ifdef SYNC_FIFO_ALMOST_FULL_EN
    assign almost_full = (r_count >= (ADDR_WIDTH+1)'(AF_LEVEL));
`endif

endmodule

// File: doc/pe_sync_fifo.md
Name: pe_sync_fifo

Overview:
- Single-clock FIFO buffering psum/ifmap/filter words between PE array stages.
- Sits directly downstream of the flag generator: generator's flag drives `rd_gate`; pops are honoured only while the gate is high.
- Write side faces the producer (GIN/PE); read side faces the consuming PE.
- Registered read data, explicit full/empty/count, sticky error flags.

Parameters:
- DATA_WIDTH, 16, width of each stored word.
- DEPTH, 8, number of entries; must be a power of two, >= 2.
- ADDR_WIDTH, 3, log2(DEPTH); pointer index width.
- AF_LEVEL, 6, almost_full threshold in entries; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push request.
- wr_data  input  DATA_WIDTH  push data.
- rd_en  input  1  pop request.
- rd_gate  input  1  read-window flag from the flag generator; pop honoured only when 1.
- rd_data  output  DATA_WIDTH  registered pop data.
- rd_valid  output  1  high for one cycle when rd_data holds a newly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: push attempted while full and not popping.
- underflow  output  1  sticky: gated pop attempted while empty.
- clear  input  1  synchronous flush; pointers and count to 0.

Behaviour:
- Reset, asynchronous:
  - wr_ptr = rd_ptr = 0, count = 0.
  - rd_data = 0, rd_valid = 0, overflow = underflow = 0.
  - empty = 1, full = 0.
  - Storage contents are not reset.
- Internal qualified strobes:
  - do_pop = rd_en & rd_gate & ~empty.
  - do_push = wr_en & (~full | do_pop).
- Push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH.
- Pop:
  - rd_data <= mem[rd_ptr]; rd_ptr <= rd_ptr + 1, wrapping modulo DEPTH.
  - rd_valid = 1 in the cycle after the pop edge.
  - rd_data holds its last value when no pop occurs; rd_valid = 0 when no pop.
- Read latency: 1 cycle from the rd_en sampling edge to rd_data/rd_valid.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push+pop.
- full and empty are combinational from count.
- Boundary conditions:
  - Full with push+pop in the same cycle: both honoured; count stays DEPTH; the write targets the slot freed by the pop.
  - Full with push only: push dropped, storage unchanged; overflow set to 1 and held until reset.
  - Empty with push+pop: push honoured, pop ignored (no fall-through); count becomes 1; rd_valid stays 0.
  - Empty with rd_en & rd_gate: pop ignored; underflow set to 1 and held.
  - rd_en with rd_gate = 0: no pop, no error, state unchanged.
  - Pointer wrap: pointers roll DEPTH-1 -> 0 seamlessly; data ordering preserved across the wrap.
- clear, synchronous, priority over push/pop in the same cycle:
  - Pointers and count go to 0; rd_valid = 0.
  - rd_data and the sticky error flags are retained.
- Reset mid-operation: immediate return to reset state; in-flight rd_valid is killed.
- No combinational path from wr_en/wr_data to rd_data.

Optional Feature:
- Macro: SYNC_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds output almost_full (1 bit) = (count >= AF_LEVEL), combinational from count, reset value 0.
  - Producer may use it as early back-pressure.
  - AF_LEVEL must satisfy 1 <= AF_LEVEL <= DEPTH.
- Undefined:
  - No almost_full port.
  - AF_LEVEL is unused; behaviour otherwise identical.

Test Plan:
- Reset then idle:
  - Required: empty=1, full=0, count=0, rd_valid=0, overflow=underflow=0.
  - Assert reset mid-stream with count=5: all of the above within the same cycle.
- Fill/drain ordering:
  - Stimulus: push 0x0001..0x0008 (DEPTH=8), then rd_en=1, rd_gate=1 for 8 cycles.
  - Required: full=1 after the 8th push; rd_data 0x0001..0x0008 in order, each one cycle after its pop; empty=1 at end.
- Gate blocking:
  - Stimulus: count=3, rd_en=1, rd_gate=0 for 4 cycles, then rd_gate=1.
  - Required: no rd_valid while gated, count stays 3; the first pop returns the oldest word.
- Full simultaneous push+pop:
  - Stimulus: full FIFO, push 0xAAAA with pop.
  - Required: count stays 8, overflow=0; after 7 more pops, 0xAAAA emerges last.
- Errors:
  - Stimulus: push while full with no pop; pop with gate while empty.
  - Required: overflow=1 and underflow=1, both sticky; data unchanged; clear does not clear them, reset does.
- Wrap and clear:
  - Stimulus: 20 interleaved push/pop cycles crossing pointer wrap twice, then clear with wr_en=1.
  - Required: ordering intact; after clear count=0, the push in the clear cycle is dropped.
  - With SYNC_FIFO_ALMOST_FULL_EN: almost_full rises exactly when count reaches 6.
